// File: rtl/conv_mem_pkg.sv
// ============================================================================
// conv_mem_pkg : geometry defaults and state encoding for conv feature maps
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_mem_pkg;

  localparam int FM_IMG_W  = 24;
  localparam int FM_IMG_H  = 24;
  localparam int FM_DATA_W = 16;
  localparam int FM_ADDR_W = 10;
  localparam int FM_WORDS  = FM_IMG_W * FM_IMG_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fm_state_e;

endpackage

`default_nettype wire

// File: rtl/fm_raster_counter.sv
// ============================================================================
// fm_raster_counter : raster row/col tracker with a linear address counter
// Rev 1.0
// ============================================================================
`default_nettype none

module fm_raster_counter
  import conv_mem_pkg::*;
#(
  parameter int IMG_W  = FM_IMG_W,
  parameter int IMG_H  = FM_IMG_H,
  parameter int ADDR_W = FM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [4:0]        row,
  output logic [4:0]        col,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [4:0] c_last_col = 5'(IMG_W - 1);
  localparam logic [4:0] c_last_row = 5'(IMG_H - 1);

  assign last = (row == c_last_row) && (col == c_last_col);

  // Address runs alongside row/col so no row*IMG_W multiply is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (col == c_last_col) begin
        col  <= '0;
        row  <= row + 5'd1;
        addr <= addr + 1'b1;
      end else begin
        col  <= col + 5'd1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv1_mem_write.sv
// ============================================================================
// conv1_mem_write : stores the conv1 pixel stream into the feature-map RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module conv1_mem_write
  import conv_mem_pkg::*;
#(
  parameter int IMG_W  = FM_IMG_W,
  parameter int IMG_H  = FM_IMG_H,
  parameter int DATA_W = FM_DATA_W,
  parameter int ADDR_W = FM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [4:0]        row,
  output logic [4:0]        col,
  output logic              done,
  output logic              overflow
);

  fm_state_e         r_state;
  logic              w_accept;
  logic              w_clear;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  assign in_ready = (r_state == WRITE);
  assign w_accept = in_valid && in_ready;
  // A start seen in WRITE must not disturb the map in progress.
  assign w_clear  = start && (r_state != WRITE);

  fm_raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .advance (w_accept),
    .row     (row),
    .col     (col),
    .addr    (w_addr),
    .last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= w_accept;
      if (w_accept) begin
        mem_addr  <= w_addr;
        mem_wdata <= in_data;
      end
      case (r_state)
        IDLE: begin
          if (start) r_state <= WRITE;
        end
        WRITE: begin
          if (w_accept && w_last) begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            r_state  <= WRITE;
            done     <= 1'b0;
            overflow <= 1'b0;
          end else if (in_valid) begin
            overflow <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv1_mem_write.sv
// ============================================================================
// tb_conv1_mem_write : directed self-checking bench for conv1_mem_write
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv1_mem_write;
  import conv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [4:0]  row;
  logic [4:0]  col;
  logic        done;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [9:0]  q_addr[$];
  logic [15:0] q_data[$];
  logic        q_done[$];

  always #5 clk = ~clk;

  conv1_mem_write dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .row       (row),
    .col       (col),
    .done      (done),
    .overflow  (overflow)
  );

  // Log every RAM write seen just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      q_addr.push_back(mem_addr);
      q_data.push_back(mem_wdata);
      q_done.push_back(done);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_row"},   32'(row),       32'd0);
    check({tag, "_col"},   32'(col),       32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_ovf"},   32'(overflow),  32'd0);
    check({tag, "_rdy"},   32'(in_ready),  32'd0);
  endtask

  task automatic beat(input logic [15:0] d);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic gap();
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_done.delete();
  endtask

  task automatic check_map(input string tag, input int base);
    check({tag, "_nwrites"}, 32'(q_addr.size()), 32'(FM_WORDS));
    if (q_addr.size() == FM_WORDS) begin
      for (int i = 0; i < FM_WORDS; i++) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(i));
        check($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(16'(base + i)));
      end
      check({tag, "_done_before_last"}, 32'(q_done[FM_WORDS-2]), 32'd0);
      check({tag, "_done_with_last"},   32'(q_done[FM_WORDS-1]), 32'd1);
    end
    check({tag, "_rdy_after"},  32'(in_ready), 32'd0);
    check({tag, "_done_after"}, 32'(done),     32'd1);
  endtask

  initial begin
    // Reset state
    #3;
    check_cleared("rst");
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back full map, data = index
    clear_q();
    pulse_start();
    for (int k = 0; k < FM_WORDS; k++) beat(16'(k));
    gap();
    check_map("t1", 0);

    // Restart from DONE, then valid toggling 1-0-1
    pulse_start();
    @(posedge clk); #1;
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_rdy", 32'(in_ready), 32'd1);
    clear_q();
    for (int k = 0; k < FM_WORDS; k++) begin
      beat(16'(k + 1000));
      if (k == 25) begin
        #1;
        check("t2_row25", 32'(row), 32'd1);
        check("t2_col25", 32'(col), 32'd1);
      end
      gap();
      if (k == 10) begin
        @(posedge clk); #1;
        check("t2_gap_we", 32'(mem_we), 32'd0);
      end
    end
    gap();
    check_map("t2", 1000);

    // Reset after beat 100, then a fresh map
    pulse_start();
    clear_q();
    for (int k = 0; k <= 100; k++) beat(16'(k + 3000));
    @(posedge clk); #3;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check_cleared("t3rst");
    check("t3_partial_writes", 32'(q_addr.size()), 32'd101);
    if (q_addr.size() > 0)
      check("t3_partial_last", 32'(q_addr[q_addr.size()-1]), 32'd100);
    @(negedge clk);
    reset = 1'b0;
    clear_q();
    pulse_start();
    for (int k = 0; k < FM_WORDS; k++) beat(16'(k + 2000));
    gap();
    check_map("t3", 2000);

    // Overflow after done
    clear_q();
    for (int k = 0; k < 3; k++) beat(16'hDEAD);
    gap();
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_nwrites", 32'(q_addr.size()), 32'd0);
    pulse_start();
    @(posedge clk); #1;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    check("t4_done_clr", 32'(done), 32'd0);

    // start mid-map (alongside beat index 300) is ignored
    clear_q();
    for (int k = 0; k < FM_WORDS; k++) begin
      if (k == 300) begin
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'(k + 4000);
      end else begin
        beat(16'(k + 4000));
      end
    end
    gap();
    check_map("t5", 4000);

    // start + in_valid together in IDLE: no write that cycle
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(posedge clk); #1;
    check("t6_no_we", 32'(mem_we), 32'd0);
    check("t6_rdy", 32'(in_ready), 32'd1);
    beat(16'h1234);
    @(posedge clk); #1;
    check("t6_we", 32'(mem_we), 32'd1);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_data", 32'(mem_wdata), 32'h1234);
    gap();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
